// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the main-memory port arbiter.
package mem_arb_pkg;

  localparam int          STARVE_LIMIT_DEF   = 4;
  localparam int          TIMEOUT_CYCLES_DEF = 64;
  localparam logic [31:0] ERR_DATA_DEF       = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT,
    ARB_RESP,
    ARB_ERR
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  typedef struct packed {
    owner_t      owner;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_txn_t;

  // Memory only ever sees word addresses; the two low bits are forced to zero.
  function automatic logic [31:0] wordAlign(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/mem_arb_select.sv
// Grant selection between I-side and D-side: D wins unless I has been
// passed over STARVE_LIMIT times in a row while it was waiting.
module mem_arb_select
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_req,
  input  logic d_req,
  input  logic arbOpen,
  output logic grant_i,
  output logic grant_d,
  output logic sel_owner
);

  localparam int            SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);

  logic [SW-1:0] r_streak;
  logic          w_starved;

  // Decide who gets the port this cycle; nothing is granted unless the arbiter is open.
  always_comb begin
    w_starved = i_req && (r_streak == STREAK_MAX);
    grant_d   = arbOpen && d_req && !w_starved;
    grant_i   = arbOpen && i_req && !grant_d;
    sel_owner = grant_d ? OWN_D : OWN_I;
  end

  // Count consecutive D grants that overtook a waiting I request, saturating at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_streak <= '0;
    end else if (grant_d) begin
      if (!i_req) begin
        r_streak <= '0;
      end else if (r_streak != STREAK_MAX) begin
        r_streak <= r_streak + SW'(1);
      end
    end else if (grant_i) begin
      r_streak <= '0;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one main-memory port between instruction fetch and data access,
// one transaction in flight, with alignment checking and a response timeout.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int          STARVE_LIMIT   = STARVE_LIMIT_DEF,
  parameter int          TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter logic [31:0] ERR_DATA       = ERR_DATA_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic        busy
);

  localparam int            TW         = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  arb_state_t    r_state;
  arb_state_t    w_nextState;
  mem_txn_t      r_txn;
  logic [TW-1:0] r_timer;
  logic [31:0]   r_rdata;
  logic          w_arbOpen;
  logic          w_grantI;
  logic          w_grantD;
  logic          w_selOwner;
  logic [31:0]   w_errData;

  // Reset is folded in so no grant can leak out while the block is held in reset.
  assign w_arbOpen = (r_state == ARB_IDLE) && rst_n;

  mem_arb_select #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_select (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_req    (i_req),
    .d_req    (d_req),
    .arbOpen  (w_arbOpen),
    .grant_i  (w_grantI),
    .grant_d  (w_grantD),
    .sel_owner(w_selOwner)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Capture the winning request; I-side is always a read with no write data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_txn <= '0;
    end else if (w_grantD || w_grantI) begin
      r_txn.owner <= owner_t'(w_selOwner);
      r_txn.we    <= w_selOwner ? d_we : 1'b0;
      r_txn.addr  <= w_selOwner ? wordAlign(d_addr) : wordAlign(i_addr);
      r_txn.wdata <= w_selOwner ? d_wdata : 32'h0;
    end
  end

  // Response timer: restarts when memory takes the request, counts idle cycles while waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer <= '0;
    end else if (r_state == ARB_ISSUE && mem_req_ready) begin
      r_timer <= '0;
    end else if (r_state == ARB_WAIT && !mem_resp_valid && r_timer != TIMER_LAST) begin
      r_timer <= r_timer + TW'(1);
    end
  end

  // Hold the memory read data for the response cycle; stores return zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (r_state == ARB_WAIT && mem_resp_valid) begin
      r_rdata <= r_txn.we ? 32'h0 : mem_resp_data;
    end
  end

  assign w_errData = (r_txn.owner == OWN_D && r_txn.we) ? 32'h0 : ERR_DATA;
  assign busy      = (r_state != ARB_IDLE);

  // Next-state and output decode; responses are steered only to the transaction owner.
  always_comb begin
    w_nextState   = r_state;
    i_gnt         = 1'b0;
    d_gnt         = 1'b0;
    i_rvalid      = 1'b0;
    i_rdata       = 32'h0;
    i_err         = 1'b0;
    d_rvalid      = 1'b0;
    d_rdata       = 32'h0;
    d_err         = 1'b0;
    mem_req_valid = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = 32'h0;
    mem_wdata     = 32'h0;

    unique case (r_state)
      ARB_IDLE: begin
        if (w_grantD) begin
          d_gnt       = 1'b1;
          w_nextState = (d_addr[1:0] != 2'b00) ? ARB_ERR : ARB_ISSUE;
        end else if (w_grantI) begin
          i_gnt       = 1'b1;
          w_nextState = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        mem_req_valid = 1'b1;
        mem_we        = r_txn.we;
        mem_addr      = r_txn.addr;
        mem_wdata     = r_txn.wdata;
        if (mem_req_ready) begin
          w_nextState = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (mem_resp_valid) begin
          w_nextState = ARB_RESP;
        end else if (r_timer == TIMER_LAST) begin
          w_nextState = ARB_ERR;
        end
      end
      ARB_RESP: begin
        if (r_txn.owner == OWN_D) begin
          d_rvalid = 1'b1;
          d_rdata  = r_rdata;
        end else begin
          i_rvalid = 1'b1;
          i_rdata  = r_rdata;
        end
        w_nextState = ARB_IDLE;
      end
      ARB_ERR: begin
        if (r_txn.owner == OWN_D) begin
          d_rvalid = 1'b1;
          d_err    = 1'b1;
          d_rdata  = w_errData;
        end else begin
          i_rvalid = 1'b1;
          i_err    = 1'b1;
          i_rdata  = w_errData;
        end
        w_nextState = ARB_IDLE;
      end
      default: begin
        w_nextState = ARB_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter: one task per scenario, each with
// hand-computed expectations.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        i_err;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        busy;

  logic        manReady;
  logic        manRespValid;
  logic [31:0] manRespData;
  logic        autoMem;
  logic        autoHs;
  logic        autoRespValid;
  logic [31:0] autoData;

  int vectors;
  int miscompares;

  mem_port_arbiter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_req         (i_req),
    .i_addr        (i_addr),
    .i_gnt         (i_gnt),
    .i_rvalid      (i_rvalid),
    .i_rdata       (i_rdata),
    .i_err         (i_err),
    .d_req         (d_req),
    .d_we          (d_we),
    .d_addr        (d_addr),
    .d_wdata       (d_wdata),
    .d_gnt         (d_gnt),
    .d_rvalid      (d_rvalid),
    .d_rdata       (d_rdata),
    .d_err         (d_err),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_data (mem_resp_data),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory side is either driven by hand or by a zero-wait responder.
  assign mem_req_ready  = autoMem ? 1'b1 : manReady;
  assign mem_resp_valid = autoMem ? autoRespValid : manRespValid;
  assign mem_resp_data  = autoMem ? autoData : manRespData;

  // Zero-wait memory: answer in the cycle after the request handshake.
  always @(negedge clk) autoHs <= autoMem && mem_req_valid && mem_req_ready;
  always @(posedge clk) begin
    autoRespValid <= autoMem && autoHs;
    autoData      <= autoData + 32'h1;
  end

  // Advance to just after the next rising edge, where inputs are changed.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before sampling, well away from the edges.
  task automatic settle();
    #2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    nextCycle();
    settle();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (mem_req_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_mem_req_valid: got %b want 0", mem_req_valid); end
    vectors++; if ({i_gnt, d_gnt, i_rvalid, d_rvalid, i_err, d_err} !== 6'b0) begin miscompares++; $display("[TB] FAIL reset_handshakes: got %b want 000000", {i_gnt, d_gnt, i_rvalid, d_rvalid, i_err, d_err}); end
    vectors++; if ({mem_addr, mem_wdata, i_rdata, d_rdata} !== 128'h0) begin miscompares++; $display("[TB] FAIL reset_data: got %h want 0", {mem_addr, mem_wdata, i_rdata, d_rdata}); end
    nextCycle();
    rst_n = 1'b1;
    settle();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_release_busy: got %b want 0", busy); end
  endtask

  task automatic test_load();
    nextCycle();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; manReady = 1'b1;
    settle();
    vectors++; if (d_gnt !== 1'b1) begin miscompares++; $display("[TB] FAIL load_gnt: got %b want 1", d_gnt); end
    vectors++; if (mem_req_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL load_valid_n: got %b want 0", mem_req_valid); end
    nextCycle();
    d_req = 1'b0;
    settle();
    vectors++; if (mem_req_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL load_valid_n1: got %b want 1", mem_req_valid); end
    vectors++; if (mem_addr !== 32'h100 || mem_we !== 1'b0) begin miscompares++; $display("[TB] FAIL load_addr: got %h/%b want 00000100/0", mem_addr, mem_we); end
    nextCycle();
    manRespValid = 1'b1; manRespData = 32'hCAFE_0001;
    settle();
    vectors++; if (d_rvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL load_rvalid_n2: got %b want 0", d_rvalid); end
    nextCycle();
    manRespValid = 1'b0; manReady = 1'b0;
    settle();
    vectors++; if (d_rvalid !== 1'b1 || d_err !== 1'b0) begin miscompares++; $display("[TB] FAIL load_rvalid_n3: got rvalid=%b err=%b want 1/0", d_rvalid, d_err); end
    vectors++; if (d_rdata !== 32'hCAFE_0001) begin miscompares++; $display("[TB] FAIL load_rdata: got %h want cafe0001", d_rdata); end
    vectors++; if (i_rvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL load_i_rvalid: got %b want 0", i_rvalid); end
    nextCycle();
    settle();
    vectors++; if (d_rvalid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("[TB] FAIL load_done: got rvalid=%b busy=%b want 0/0", d_rvalid, busy); end
  endtask

  task automatic test_misaligned();
    nextCycle();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h202; d_wdata = 32'h1234_5678;
    settle();
    vectors++; if (d_gnt !== 1'b1 || mem_req_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL misalign_gnt: got gnt=%b valid=%b want 1/0", d_gnt, mem_req_valid); end
    nextCycle();
    d_req = 1'b0;
    settle();
    vectors++; if (d_rvalid !== 1'b1 || d_err !== 1'b1) begin miscompares++; $display("[TB] FAIL misalign_err: got rvalid=%b err=%b want 1/1", d_rvalid, d_err); end
    vectors++; if (d_rdata !== 32'h0) begin miscompares++; $display("[TB] FAIL misalign_rdata: got %h want 00000000", d_rdata); end
    vectors++; if (mem_req_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL misalign_no_mem: got %b want 0", mem_req_valid); end
    nextCycle();
    settle();
    vectors++; if (busy !== 1'b0 || d_rvalid !== 1'b0 || mem_req_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL misalign_idle: got busy=%b rvalid=%b valid=%b want 0/0/0", busy, d_rvalid, mem_req_valid); end
  endtask

  task automatic test_back_to_back();
    bit expD [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    bit gotD [10];
    int gCount = 0;
    int iRv = 0;
    int dRv = 0;
    int both = 0;
    bit dropNow = 1'b0;
    bit done = 1'b0;
    nextCycle();
    autoMem = 1'b1;
    i_req = 1'b1; i_addr = 32'h800;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
    for (int cyc = 0; cyc < 80 && !done; cyc++) begin
      if (dropNow) begin i_req = 1'b0; d_req = 1'b0; end
      settle();
      if (d_gnt && i_gnt) both++;
      if (d_gnt || i_gnt) begin
        if (gCount < 10) gotD[gCount] = d_gnt;
        gCount++;
        if (gCount == 10) dropNow = 1'b1;
      end
      if (d_rvalid) dRv++;
      if (i_rvalid) iRv++;
      if (gCount >= 10 && (iRv + dRv) >= 10 && !busy) done = 1'b1;
      else nextCycle();
    end
    i_req = 1'b0; d_req = 1'b0;
    vectors++; if (gCount !== 10) begin miscompares++; $display("[TB] FAIL b2b_grant_count: got %0d want 10 within cycle budget", gCount); end
    for (int k = 0; k < 10; k++) begin
      vectors++; if (gotD[k] !== expD[k]) begin miscompares++; $display("[TB] FAIL b2b_order[%0d]: got %s want %s", k, gotD[k] ? "D" : "I", expD[k] ? "D" : "I"); end
    end
    vectors++; if (iRv !== 2 || dRv !== 8) begin miscompares++; $display("[TB] FAIL b2b_responses: got i=%0d d=%0d want 2/8", iRv, dRv); end
    vectors++; if (both !== 0) begin miscompares++; $display("[TB] FAIL b2b_dual_gnt: got %0d cycles want 0", both); end
    nextCycle();
    autoMem = 1'b0;
    nextCycle();
  endtask

  task automatic test_timeout();
    int early = 0;
    nextCycle();
    i_req = 1'b1; i_addr = 32'h40; manReady = 1'b1;
    settle();
    vectors++; if (i_gnt !== 1'b1) begin miscompares++; $display("[TB] FAIL timeout_gnt: got %b want 1", i_gnt); end
    nextCycle();
    i_req = 1'b0;
    settle();
    vectors++; if (mem_req_valid !== 1'b1 || mem_addr !== 32'h40) begin miscompares++; $display("[TB] FAIL timeout_issue: got %b/%h want 1/00000040", mem_req_valid, mem_addr); end
    nextCycle();
    manReady = 1'b0;
    for (int k = 0; k < 64; k++) begin
      settle();
      if (i_rvalid !== 1'b0 || busy !== 1'b1) early++;
      nextCycle();
    end
    vectors++; if (early !== 0) begin miscompares++; $display("[TB] FAIL timeout_early: got %0d bad wait cycles want 0", early); end
    settle();
    vectors++; if (i_rvalid !== 1'b1 || i_err !== 1'b1) begin miscompares++; $display("[TB] FAIL timeout_err: got rvalid=%b err=%b want 1/1", i_rvalid, i_err); end
    vectors++; if (i_rdata !== 32'hDEAD_BEEF) begin miscompares++; $display("[TB] FAIL timeout_rdata: got %h want deadbeef", i_rdata); end
    vectors++; if (d_rvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL timeout_d_rvalid: got %b want 0", d_rvalid); end
    nextCycle();
    nextCycle();
    manRespValid = 1'b1; manRespData = 32'h1111_1111;
    settle();
    vectors++; if (i_rvalid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("[TB] FAIL late_resp_same: got rvalid=%b busy=%b want 0/0", i_rvalid, busy); end
    nextCycle();
    manRespValid = 1'b0;
    settle();
    vectors++; if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL late_resp_after: got i=%b d=%b want 0/0", i_rvalid, d_rvalid); end
  endtask

  task automatic test_stall();
    nextCycle();
    i_req = 1'b1; i_addr = 32'h1234_5677; manReady = 1'b0;
    settle();
    vectors++; if (i_gnt !== 1'b1) begin miscompares++; $display("[TB] FAIL stall_gnt: got %b want 1", i_gnt); end
    nextCycle();
    i_addr = 32'h88;
    for (int k = 0; k < 5; k++) begin
      settle();
      vectors++; if (mem_req_valid !== 1'b1 || mem_addr !== 32'h1234_5674) begin miscompares++; $display("[TB] FAIL stall_hold[%0d]: got %b/%h want 1/12345674", k, mem_req_valid, mem_addr); end
      vectors++; if (busy !== 1'b1 || i_gnt !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_busy[%0d]: got busy=%b gnt=%b want 1/0", k, busy, i_gnt); end
      nextCycle();
    end
    manReady = 1'b1;
    nextCycle();
    manReady = 1'b0; manRespValid = 1'b1; manRespData = 32'h0000_600D;
    settle();
    vectors++; if (i_gnt !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_wait_gnt: got %b want 0", i_gnt); end
    nextCycle();
    manRespValid = 1'b0;
    settle();
    vectors++; if (i_rvalid !== 1'b1 || i_rdata !== 32'h0000_600D || i_gnt !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_resp: got rvalid=%b rdata=%h gnt=%b want 1/0000600d/0", i_rvalid, i_rdata, i_gnt); end
    nextCycle();
    settle();
    vectors++; if (i_gnt !== 1'b1) begin miscompares++; $display("[TB] FAIL stall_regrant: got %b want 1", i_gnt); end
    nextCycle();
    i_req = 1'b0; manReady = 1'b1;
    settle();
    vectors++; if (mem_addr !== 32'h88) begin miscompares++; $display("[TB] FAIL stall_second_addr: got %h want 00000088", mem_addr); end
    nextCycle();
    manReady = 1'b0; manRespValid = 1'b1; manRespData = 32'h0;
    nextCycle();
    manRespValid = 1'b0;
    nextCycle();
  endtask

  task automatic test_reset_mid();
    nextCycle();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500; manReady = 1'b1;
    nextCycle();
    d_req = 1'b0;
    nextCycle();
    manReady = 1'b0;
    settle();
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL rstmid_pre_busy: got %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    vectors++; if (busy !== 1'b0 || mem_req_valid !== 1'b0 || d_rvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL rstmid_async: got busy=%b valid=%b rvalid=%b want 0/0/0", busy, mem_req_valid, d_rvalid); end
    nextCycle();
    rst_n = 1'b1; manRespValid = 1'b1; manRespData = 32'h0000_0BAD;
    settle();
    vectors++; if (d_rvalid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rstmid_late_resp: got rvalid=%b busy=%b want 0/0", d_rvalid, busy); end
    nextCycle();
    manRespValid = 1'b0;
    d_req = 1'b1; d_addr = 32'h300;
    settle();
    vectors++; if (d_rvalid !== 1'b0 || d_gnt !== 1'b1) begin miscompares++; $display("[TB] FAIL rstmid_regrant: got rvalid=%b gnt=%b want 0/1", d_rvalid, d_gnt); end
    nextCycle();
    d_req = 1'b0; manReady = 1'b1;
    nextCycle();
    manReady = 1'b0; manRespValid = 1'b1; manRespData = 32'h0300_0300;
    nextCycle();
    manRespValid = 1'b0;
    settle();
    vectors++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h0300_0300) begin miscompares++; $display("[TB] FAIL rstmid_resp: got %b/%h want 1/03000300", d_rvalid, d_rdata); end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst_n = 1'b0;
    i_req = 1'b0; i_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
    manReady = 1'b0; manRespValid = 1'b0; manRespData = 32'h0;
    autoMem = 1'b0; autoHs = 1'b0; autoRespValid = 1'b0; autoData = 32'h0;
    $display("[TB] starting mem_port_arbiter bench");
    test_reset();
    test_load();
    test_misaligned();
    test_back_to_back();
    test_timeout();
    test_stall();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single main-memory port between the instruction-fetch requester (I-side, read-only) and the memory-access stage / data cache (D-side, read/write).
- Holds one outstanding transaction at a time and routes the response back to its owner.
- D-side has priority, with a starvation guard for I-side.
- Adds word-alignment checking and a response timeout.

Parameters:
- STARVE_LIMIT, 4: consecutive D grants with i_req pending, after which the next grant goes to I.
- TIMEOUT_CYCLES, 64: cycles in WAIT_RESP before the transaction is aborted with an error.
- ERR_DATA, 32'hDEAD_BEEF: read data returned on error.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: reset.
- i_req, input, 1: I-side request; held with i_addr until i_gnt.
- i_addr, input, 32: I-side read address.
- i_gnt, output, 1: I request accepted (1-cycle pulse).
- i_rvalid, output, 1: I response valid (1-cycle pulse).
- i_rdata, output, 32: I read data.
- i_err, output, 1: I error, qualified by i_rvalid.
- d_req, input, 1: D-side request; held with d_we, d_addr, d_wdata until d_gnt.
- d_we, input, 1: 1 = store word, 0 = load word.
- d_addr, input, 32: D address.
- d_wdata, input, 32: store data.
- d_gnt, output, 1: D request accepted (1-cycle pulse).
- d_rvalid, output, 1: D response valid (1-cycle pulse).
- d_rdata, output, 32: load data; 0 for stores.
- d_err, output, 1: D error, qualified by d_rvalid.
- mem_req_valid, output, 1: memory request valid.
- mem_req_ready, input, 1: memory accepts the request.
- mem_we, output, 1: memory write enable.
- mem_addr, output, 32: memory address; bits [1:0] always 0.
- mem_wdata, output, 32: memory write data.
- mem_resp_valid, input, 1: memory response; for writes this is the write acknowledge.
- mem_resp_data, input, 32: memory read data.
- busy, output, 1: high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: all outputs 0; state IDLE; streak 0; timeout counter 0; latched request registers 0.
- Reset mid-transaction: immediate return to IDLE, no response issued. A memory response arriving after reset is ignored.
- FSM states: IDLE, ISSUE, WAIT_RESP, RESP, ERR_RESP.
- IDLE, grant selection (combinational):
  - If d_req and !(i_req && streak==STARVE_LIMIT), grant D.
  - Otherwise, if i_req, grant I.
  - The gnt pulse occurs in the same cycle. Owner, we, addr and wdata are latched (I-side: we=0, wdata=0).
- IDLE, next state:
  - D grant with d_addr[1:0]!=0 goes to ERR_RESP, with no memory transaction.
  - Any other grant goes to ISSUE.
- Streak counter:
  - On a D grant with i_req high: streak+1, saturating at STARVE_LIMIT.
  - On a D grant with i_req low: streak 0.
  - On an I grant: streak 0.
- I-side alignment: i_addr[1:0] is ignored; mem_addr is always {addr[31:2],2'b00}.
- ISSUE:
  - mem_req_valid=1 with the latched mem_we, mem_addr and mem_wdata held stable.
  - On mem_req_ready, go to WAIT_RESP and clear the timeout counter.
- WAIT_RESP:
  - mem_resp_valid: capture the data (0 if the transaction was a write) and go to RESP.
  - Otherwise the counter increments. When counter==TIMEOUT_CYCLES-1, go to ERR_RESP.
- RESP: owner's rvalid=1 for exactly one cycle, with rdata = captured data and err=0; then IDLE.
- ERR_RESP: owner's rvalid=1 and err=1 for one cycle, with rdata=ERR_DATA (0 for D stores); then IDLE.
- mem_resp_valid outside WAIT_RESP: ignored, including late responses after a timeout.
- Minimum load latency:
  - req at cycle N gives gnt at N and mem_req_valid at N+1.
  - With ready at N+1 and resp at N+2, rvalid is at N+3.
- No new grant while busy. Requests stay pending, and gnt stays 0.
- Responses go only to the owner; the other side's rvalid stays 0.

Decomposition:
- Shared package mem_arb_pkg:
  - State enum: ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP, ARB_ERR.
  - Owner enum: OWN_I, OWN_D.
  - Default parameter constants.
  - Struct mem_txn_t: owner, we, addr, wdata.
- One sub-module, mem_arb_select: combinational grant selection plus the streak register and its saturation. It outputs grant_i, grant_d and sel_owner.

Test Plan:
- D load, address 32'h100, ready the same cycle, resp 32'hCAFE_0001 one cycle later: d_gnt at N, mem_req_valid at N+1, d_rvalid at N+3 with d_rdata=32'hCAFE_0001, d_err=0; i_rvalid stays 0.
- I and D requesting every cycle, memory with zero wait: grant order D,D,D,D,I,D,D,D,D,I; the streak resets after each I grant.
- D store, d_addr=32'h202 (misaligned): d_gnt, then d_rvalid with d_err=1 and d_rdata=0 one cycle later; mem_req_valid is never asserted.
- I fetch, memory never responds: after 64 cycles in WAIT_RESP, i_rvalid=1, i_err=1, i_rdata=32'hDEAD_BEEF. A mem_resp_valid injected 2 cycles later produces no rvalid.
- mem_req_ready held low 5 cycles: mem_req_valid and mem_addr are stable for all 5 cycles, busy=1, and a new i_req is not granted until return to IDLE.
- rst_n asserted in WAIT_RESP: all outputs 0 asynchronously; the response after release is ignored, and the next d_req is granted normally.
